// File: rtl/cart_map_mux.sv
// Cartridge mapper select: multiplexes N mapper channels onto the shared CPU/ROM/BSRAM buses.
// Optional macro CART_MAP_MUX_OUTREG_EN registers all data/control outputs (+1 cycle latency).
module cart_map_mux #(
  parameter int          N           = 5,
  parameter int          DEF_CH      = 0,
  parameter int          STABLE_CYC  = 4,
  parameter int          QUIESCE_CYC = 2,
  parameter logic [7:0]  IDLE_DI     = 8'hFF,
  parameter int          IDXW        = $clog2(N)
) (
  input  logic              mclk,
  input  logic              rst,
  input  logic [N-1:0]      map_active,
  input  logic [8*N-1:0]    ch_do,
  input  logic [N-1:0]      ch_irq_n,
  input  logic [24*N-1:0]   ch_rom_addr,
  input  logic [N-1:0]      ch_rom_ce_n,
  input  logic [N-1:0]      ch_rom_oe_n,
  input  logic [N-1:0]      ch_rom_word,
  input  logic [20*N-1:0]   ch_bsram_addr,
  input  logic [8*N-1:0]    ch_bsram_d,
  input  logic [N-1:0]      ch_bsram_ce_n,
  input  logic [N-1:0]      ch_bsram_oe_n,
  input  logic [N-1:0]      ch_bsram_we_n,
  output logic [7:0]        di,
  output logic              irq_n,
  output logic [23:0]       rom_addr,
  output logic              rom_ce_n,
  output logic              rom_oe_n,
  output logic              rom_word,
  output logic [19:0]       bsram_addr,
  output logic [7:0]        bsram_d,
  output logic              bsram_ce_n,
  output logic              bsram_oe_n,
  output logic              bsram_we_n,
  output logic [IDXW-1:0]   sel_idx,
  output logic              switching,
  output logic              conflict
);

  typedef enum logic {ST_RUN, ST_QUIESCE} state_t;

  typedef struct packed {
    logic [7:0]  di;
    logic        irq_n;
    logic [23:0] rom_addr;
    logic        rom_ce_n;
    logic        rom_oe_n;
    logic        rom_word;
    logic [19:0] bsram_addr;
    logic [7:0]  bsram_d;
    logic        bsram_ce_n;
    logic        bsram_oe_n;
    logic        bsram_we_n;
  } bus_t;

  localparam logic [7:0]      STAB_LIM = 8'(STABLE_CYC);
  localparam logic [7:0]      Q_INIT   = 8'(QUIESCE_CYC);
  localparam logic [IDXW-1:0] DEF_IDX  = IDXW'(DEF_CH);

  state_t          r_state, w_state_nxt;
  logic [7:0]      r_q_cnt, w_q_cnt_nxt;
  logic [7:0]      r_stab_cnt, w_stab_nxt;
  logic [IDXW-1:0] r_sel, w_sel_nxt;
  logic [IDXW-1:0] r_cand, w_cand_nxt;
  logic            r_conflict, w_conflict_nxt;

  // Per-channel unpack of the flat input buses
  logic [N-1:0][7:0]  w_do, w_bsd;
  logic [N-1:0][23:0] w_ra;
  logic [N-1:0][19:0] w_ba;

  for (genvar k = 0; k < N; k++) begin : g_ch
    assign w_do[k]  = ch_do[8*k +: 8];
    assign w_bsd[k] = ch_bsram_d[8*k +: 8];
    assign w_ra[k]  = ch_rom_addr[24*k +: 24];
    assign w_ba[k]  = ch_bsram_addr[20*k +: 20];
  end

  // Target decode; the default channel's own flag never counts
  logic [N-1:0]    w_masked;
  logic [4:0]      w_hot_cnt;
  logic [IDXW-1:0] w_target;
  logic            w_multi;

  always_comb begin
    w_masked         = map_active;
    w_masked[DEF_CH] = 1'b0;
    w_hot_cnt        = '0;
    w_target         = DEF_IDX;
    for (int k = 0; k < N; k++) begin
      if (w_masked[k]) begin
        w_hot_cnt = w_hot_cnt + 5'd1;
        w_target  = IDXW'(k);
      end
    end
    w_multi = (w_hot_cnt > 5'd1);
  end

  always_ff @(posedge mclk) begin
    if (rst) begin
      r_state    <= ST_QUIESCE;
      r_q_cnt    <= Q_INIT;
      r_stab_cnt <= '0;
      r_sel      <= DEF_IDX;
      r_cand     <= DEF_IDX;
      r_conflict <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_q_cnt    <= w_q_cnt_nxt;
      r_stab_cnt <= w_stab_nxt;
      r_sel      <= w_sel_nxt;
      r_cand     <= w_cand_nxt;
      r_conflict <= w_conflict_nxt;
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_q_cnt_nxt    = r_q_cnt;
    w_stab_nxt     = r_stab_cnt;
    w_sel_nxt      = r_sel;
    w_cand_nxt     = r_cand;
    w_conflict_nxt = r_conflict;
    case (r_state)
      ST_QUIESCE: begin
        w_stab_nxt = '0;
        if (r_q_cnt <= 8'd1) begin
          w_q_cnt_nxt = '0;
          w_state_nxt = ST_RUN;
        end else begin
          w_q_cnt_nxt = r_q_cnt - 8'd1;
        end
      end
      default: begin
        if (w_multi) begin
          w_conflict_nxt = 1'b1;
          w_stab_nxt     = '0;
        end else if (w_target == r_sel) begin
          w_stab_nxt = '0;
        end else if (w_target == r_cand) begin
          w_stab_nxt = r_stab_cnt + 8'd1;
        end else begin
          w_cand_nxt = w_target;
          w_stab_nxt = 8'd1;
        end
        // Commit uses the updated candidate so STABLE_CYC=1 switches on first sight
        if (!w_multi && (w_target != r_sel) && (w_stab_nxt == STAB_LIM)) begin
          w_sel_nxt   = w_cand_nxt;
          w_stab_nxt  = '0;
          w_q_cnt_nxt = Q_INIT;
          w_state_nxt = ST_QUIESCE;
        end
      end
    endcase
  end

  bus_t w_idle, w_chan, w_bus_nxt, w_bus;
  logic w_force;

  always_comb begin
    w_idle            = '0;
    w_idle.di         = IDLE_DI;
    w_idle.irq_n      = 1'b1;
    w_idle.rom_ce_n   = 1'b1;
    w_idle.rom_oe_n   = 1'b1;
    w_idle.bsram_ce_n = 1'b1;
    w_idle.bsram_oe_n = 1'b1;
    w_idle.bsram_we_n = 1'b1;

    w_chan.di         = w_do[r_sel];
    w_chan.irq_n      = ch_irq_n[r_sel];
    w_chan.rom_addr   = w_ra[r_sel];
    w_chan.rom_ce_n   = ch_rom_ce_n[r_sel];
    w_chan.rom_oe_n   = ch_rom_oe_n[r_sel];
    w_chan.rom_word   = ch_rom_word[r_sel];
    w_chan.bsram_addr = w_ba[r_sel];
    w_chan.bsram_d    = w_bsd[r_sel];
    w_chan.bsram_ce_n = ch_bsram_ce_n[r_sel];
    w_chan.bsram_oe_n = ch_bsram_oe_n[r_sel];
    w_chan.bsram_we_n = ch_bsram_we_n[r_sel];
  end

  // Strobes stay inactive while reset is held, not only after the first reset edge
  assign w_force   = rst || (r_state == ST_QUIESCE);
  assign w_bus_nxt = w_force ? w_idle : w_chan;

`ifdef CART_MAP_MUX_OUTREG_EN
  bus_t r_bus;
  always_ff @(posedge mclk) begin
    if (rst) r_bus <= w_idle;
    else     r_bus <= w_bus_nxt;
  end
  assign w_bus = r_bus;
`else
  assign w_bus = w_bus_nxt;
`endif

  assign di         = w_bus.di;
  assign irq_n      = w_bus.irq_n;
  assign rom_addr   = w_bus.rom_addr;
  assign rom_ce_n   = w_bus.rom_ce_n;
  assign rom_oe_n   = w_bus.rom_oe_n;
  assign rom_word   = w_bus.rom_word;
  assign bsram_addr = w_bus.bsram_addr;
  assign bsram_d    = w_bus.bsram_d;
  assign bsram_ce_n = w_bus.bsram_ce_n;
  assign bsram_oe_n = w_bus.bsram_oe_n;
  assign bsram_we_n = w_bus.bsram_we_n;

  assign sel_idx    = r_sel;
  assign switching  = (r_state == ST_QUIESCE);
  assign conflict   = r_conflict;

endmodule

// File: tb/tb_cart_map_mux.sv
// Bench for cart_map_mux: directed scenarios plus random flag sequences against a history-based model.
module tb_cart_map_mux;
  localparam int N   = 5;
  localparam int DEF = 0;
  localparam int S   = 4;
  localparam int QC  = 2;
`ifdef CART_MAP_MUX_OUTREG_EN
  localparam int LAT = 1;
`else
  localparam int LAT = 0;
`endif

  logic            mclk = 1'b0;
  logic            rst  = 1'b1;
  logic [N-1:0]    map_active = '0;
  logic [8*N-1:0]  ch_do = '0;
  logic [N-1:0]    ch_irq_n = '0;
  logic [24*N-1:0] ch_rom_addr = '0;
  logic [N-1:0]    ch_rom_ce_n = '0, ch_rom_oe_n = '0, ch_rom_word = '0;
  logic [20*N-1:0] ch_bsram_addr = '0;
  logic [8*N-1:0]  ch_bsram_d = '0;
  logic [N-1:0]    ch_bsram_ce_n = '0, ch_bsram_oe_n = '0, ch_bsram_we_n = '0;
  logic [7:0]      di;
  logic            irq_n;
  logic [23:0]     rom_addr;
  logic            rom_ce_n, rom_oe_n, rom_word;
  logic [19:0]     bsram_addr;
  logic [7:0]      bsram_d;
  logic            bsram_ce_n, bsram_oe_n, bsram_we_n;
  logic [2:0]      sel_idx;
  logic            switching, conflict;

  cart_map_mux #(.N(N), .DEF_CH(DEF), .STABLE_CYC(S), .QUIESCE_CYC(QC), .IDLE_DI(8'hFF)) dut (
    .mclk(mclk), .rst(rst), .map_active(map_active),
    .ch_do(ch_do), .ch_irq_n(ch_irq_n), .ch_rom_addr(ch_rom_addr),
    .ch_rom_ce_n(ch_rom_ce_n), .ch_rom_oe_n(ch_rom_oe_n), .ch_rom_word(ch_rom_word),
    .ch_bsram_addr(ch_bsram_addr), .ch_bsram_d(ch_bsram_d),
    .ch_bsram_ce_n(ch_bsram_ce_n), .ch_bsram_oe_n(ch_bsram_oe_n), .ch_bsram_we_n(ch_bsram_we_n),
    .di(di), .irq_n(irq_n), .rom_addr(rom_addr), .rom_ce_n(rom_ce_n), .rom_oe_n(rom_oe_n),
    .rom_word(rom_word), .bsram_addr(bsram_addr), .bsram_d(bsram_d),
    .bsram_ce_n(bsram_ce_n), .bsram_oe_n(bsram_oe_n), .bsram_we_n(bsram_we_n),
    .sel_idx(sel_idx), .switching(switching), .conflict(conflict)
  );

  always #5 mclk = ~mclk;

  int checks = 0;
  int failures = 0;

  // Model: selected channel, forced cycles remaining, sticky conflict, recent RUN targets (-1 = multi-hot)
  int  m_sel = DEF;
  int  m_q = QC;
  bit  m_conf = 1'b0;
  int  hist[$];
  bit  pin_ch0 = 1'b0;
  bit  pin_we2 = 1'b0;
  logic [66:0] exp_bus;
  logic [71:0] exp_all;
  wire  [71:0] obs_all = {di, irq_n, rom_addr, rom_ce_n, rom_oe_n, rom_word, bsram_addr, bsram_d,
                          bsram_ce_n, bsram_oe_n, bsram_we_n, sel_idx, switching, conflict};

  function automatic logic [66:0] calc_bus(input bit forced, input int s);
    if (forced) return {8'hFF, 1'b1, 24'h0, 1'b1, 1'b1, 1'b0, 20'h0, 8'h0, 3'b111};
    return {ch_do[8*s +: 8], ch_irq_n[s], ch_rom_addr[24*s +: 24], ch_rom_ce_n[s], ch_rom_oe_n[s],
            ch_rom_word[s], ch_bsram_addr[20*s +: 20], ch_bsram_d[8*s +: 8],
            ch_bsram_ce_n[s], ch_bsram_oe_n[s], ch_bsram_we_n[s]};
  endfunction

  function automatic int decode(input logic [N-1:0] act);
    int c = 0;
    int idx = DEF;
    for (int k = 0; k < N; k++)
      if (k != DEF && act[k]) begin c++; idx = k; end
    return (c > 1) ? -1 : idx;
  endfunction

  task automatic model_update(input bit r, input logic [N-1:0] act);
    int  t;
    bit  same;
    if (r) begin
      m_sel = DEF; m_q = QC; m_conf = 1'b0; hist.delete();
    end else if (m_q > 0) begin
      m_q--;
    end else begin
      t = decode(act);
      if (t < 0) m_conf = 1'b1;
      hist.push_back(t);
      if (hist.size() > S) void'(hist.pop_front());
      if (hist.size() == S && t >= 0 && t != m_sel) begin
        same = 1'b1;
        foreach (hist[j]) if (hist[j] != t) same = 1'b0;
        if (same) begin m_sel = t; m_q = QC; hist.delete(); end
      end
    end
  endtask

  // One clock: drive inputs with fresh channel data, advance the model, then settle for sampling
  task automatic step(input bit r, input logic [N-1:0] act);
    logic [66:0] pre;
    rst = r;
    map_active = act;
    ch_do = 40'({$urandom, $urandom});
    ch_bsram_d = 40'({$urandom, $urandom});
    ch_rom_addr = 120'({$urandom, $urandom, $urandom, $urandom});
    ch_bsram_addr = 100'({$urandom, $urandom, $urandom, $urandom});
    ch_irq_n = N'($urandom); ch_rom_ce_n = N'($urandom); ch_rom_oe_n = N'($urandom);
    ch_rom_word = N'($urandom); ch_bsram_ce_n = N'($urandom); ch_bsram_oe_n = N'($urandom);
    ch_bsram_we_n = N'($urandom);
    if (pin_ch0) ch_rom_addr[23:0] = 24'h00FFC0;
    if (pin_we2) ch_bsram_we_n[2] = 1'b0;
    #1;
    pre = calc_bus(r || (m_q > 0), m_sel);
    @(posedge mclk);
    model_update(r, act);
    #1;
    exp_bus = (LAT == 1) ? pre : calc_bus(r || (m_q > 0), m_sel);
    exp_all = {exp_bus, 3'(m_sel), (m_q > 0), m_conf};
  endtask

  task automatic test_reset();
    pin_ch0 = 1'b1;
    for (int i = 0; i < 2; i++) begin
      step(1'b1, '0);
      checks++;
      if (obs_all !== exp_all) begin failures++; $display("FAIL reset_hold%0d got=%h exp=%h", i, obs_all, exp_all); end
      checks++;
      if ({switching, conflict, sel_idx} !== 5'b10000) begin
        failures++; $display("FAIL reset_state got=%b exp=10000", {switching, conflict, sel_idx});
      end
    end
    for (int i = 1; i <= 4; i++) begin
      step(1'b0, '0);
      checks++;
      if (obs_all !== exp_all) begin failures++; $display("FAIL reset_rel%0d got=%h exp=%h", i, obs_all, exp_all); end
      checks++;
      if (rom_addr !== ((i >= 2 + LAT) ? 24'h00FFC0 : 24'h0)) begin
        failures++; $display("FAIL reset_romaddr%0d got=%h exp=%h", i, rom_addr, (i >= 2 + LAT) ? 24'h00FFC0 : 24'h0);
      end
      if (i == 1) begin
        checks++;
        if ({rom_ce_n, di} !== 9'h1FF) begin failures++; $display("FAIL reset_forced got=%h exp=1ff", {rom_ce_n, di}); end
      end
    end
    pin_ch0 = 1'b0;
  endtask

  task automatic test_switch();
    pin_we2 = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      step(1'b0, 5'b00100);
      checks++;
      if (obs_all !== exp_all) begin failures++; $display("FAIL switch%0d got=%h exp=%h", i, obs_all, exp_all); end
      checks++;
      if ({sel_idx, switching} !== {3'((i >= 4) ? 2 : 0), (i == 4 || i == 5)}) begin
        failures++; $display("FAIL switch_sel%0d got=%b exp=%b", i, {sel_idx, switching}, {3'((i >= 4) ? 2 : 0), (i == 4 || i == 5)});
      end
      if (i == 5) begin
        checks++;
        if (bsram_we_n !== 1'b1) begin failures++; $display("FAIL switch_we got=%b exp=1", bsram_we_n); end
      end
    end
    pin_we2 = 1'b0;
  endtask

  task automatic test_glitch();
    for (int i = 1; i <= 6; i++) begin
      step(1'b0, (i <= 3) ? 5'b01000 : 5'b00100);
      checks++;
      if (obs_all !== exp_all) begin failures++; $display("FAIL glitch%0d got=%h exp=%h", i, obs_all, exp_all); end
      checks++;
      if ({sel_idx, switching} !== 4'b0100) begin failures++; $display("FAIL glitch_sel%0d got=%b exp=0100", i, {sel_idx, switching}); end
    end
  endtask

  task automatic test_retarget();
    for (int i = 1; i <= 6; i++) begin
      step(1'b0, (i <= 2) ? 5'b01000 : 5'b10000);
      checks++;
      if (obs_all !== exp_all) begin failures++; $display("FAIL retarget%0d got=%h exp=%h", i, obs_all, exp_all); end
      checks++;
      if (sel_idx !== 3'((i == 6) ? 4 : 2)) begin failures++; $display("FAIL retarget_sel%0d got=%0d exp=%0d", i, sel_idx, (i == 6) ? 4 : 2); end
    end
    for (int i = 0; i < 2; i++) step(1'b0, 5'b10000);
  endtask

  task automatic test_conflict();
    step(1'b0, 5'b01010);
    checks++;
    if ({conflict, sel_idx} !== 4'b1100) begin failures++; $display("FAIL conflict_set got=%b exp=1100", {conflict, sel_idx}); end
    for (int i = 0; i < 8; i++) begin
      step(1'b0, '0);
      checks++;
      if (obs_all !== exp_all) begin failures++; $display("FAIL conflict_hold%0d got=%h exp=%h", i, obs_all, exp_all); end
      checks++;
      if (conflict !== 1'b1) begin failures++; $display("FAIL conflict_sticky%0d got=%b exp=1", i, conflict); end
    end
    step(1'b1, '0);
    checks++;
    if (conflict !== 1'b0) begin failures++; $display("FAIL conflict_clr got=%b exp=0", conflict); end
    step(1'b0, '0);
    step(1'b0, '0);
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 6; i++) step(1'b0, 5'b00100);
    for (int i = 0; i < 4; i++) step(1'b0, 5'b10000);
    checks++;
    if ({sel_idx, switching} !== 4'b1001) begin failures++; $display("FAIL midrst_pre got=%b exp=1001", {sel_idx, switching}); end
    step(1'b1, 5'b10000);
    checks++;
    if ({sel_idx, switching} !== 4'b0001) begin failures++; $display("FAIL midrst_rst got=%b exp=0001", {sel_idx, switching}); end
    for (int i = 1; i <= 2; i++) begin
      step(1'b0, '0);
      checks++;
      if (obs_all !== exp_all) begin failures++; $display("FAIL midrst%0d got=%h exp=%h", i, obs_all, exp_all); end
      checks++;
      if ({sel_idx, switching} !== {3'd0, (i == 1)}) begin
        failures++; $display("FAIL midrst_sw%0d got=%b exp=%b", i, {sel_idx, switching}, {3'd0, (i == 1)});
      end
    end
  endtask

  task automatic test_random();
    logic [N-1:0] pats [7];
    logic [N-1:0] act = '0;
    int hold = 0;
    pats[0] = 5'b00000; pats[1] = 5'b00100; pats[2] = 5'b01000; pats[3] = 5'b10000;
    pats[4] = 5'b00010; pats[5] = 5'b00001; pats[6] = 5'b01010;
    for (int i = 0; i < 500; i++) begin
      if (hold == 0) begin
        act = pats[$urandom_range(6)];
        hold = $urandom_range(6, 1);
      end
      hold--;
      step(($urandom_range(63) == 0), act);
      checks++;
      if (obs_all !== exp_all) begin failures++; $display("FAIL random%0d got=%h exp=%h", i, obs_all, exp_all); end
    end
  endtask

  initial begin
    test_reset();
    test_switch();
    test_glitch();
    test_retarget();
    test_conflict();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
